// File: rtl/clock_pkg.sv
// Shared types and limits for the BCD time base.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;
  localparam logic [7:0] HR_MAX  = 8'h23;
  localparam logic [7:0] CS_MAX  = 8'h99;

  typedef enum logic {TK_RUN, TK_SET} tk_state_t;

  // 24h BCD hour -> 12h BCD hour (00 shows as 12)
  function automatic logic [7:0] to_12h(logic [7:0] h);
    case (h)
      8'h00:   return 8'h12;
      8'h13:   return 8'h01;
      8'h14:   return 8'h02;
      8'h15:   return 8'h03;
      8'h16:   return 8'h04;
      8'h17:   return 8'h05;
      8'h18:   return 8'h06;
      8'h19:   return 8'h07;
      8'h20:   return 8'h08;
      8'h21:   return 8'h09;
      8'h22:   return 8'h10;
      8'h23:   return 8'h11;
      default: return h;
    endcase
  endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter wrapping at {MAX_TENS,MAX_ONES}; carry_out flags the wrap.
module bcd_pair_counter
  import clock_pkg::*;
#(
  parameter bcd_t MAX_TENS = 4'd9,
  parameter bcd_t MAX_ONES = 4'd9
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic carry_out,
  output bcd_t tens,
  output bcd_t ones
);

  logic at_max;

  assign at_max    = (tens == MAX_TENS) && (ones == MAX_ONES);
  assign carry_out = inc && at_max;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      if (at_max) begin
        tens <= '0;
        ones <= '0;
      end else if (ones == 4'd9) begin
        tens <= tens + 4'd1;
        ones <= '0;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_timekeeper.sv
// BCD hh:mm:ss.cc time base with prescaler, set mode, hold-to-repeat and 12/24h display.
// Optional alarm compare enabled by defining BCD_TIMEKEEPER_ALARM_EN.
module bcd_timekeeper
  import clock_pkg::*;
#(
  parameter int CLK_HZ       = 10000,
  parameter int TICK_HZ      = 100,
  parameter int REPEAT_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       setting_enable,
  input  logic       set_hr_or_min,
  input  logic       inc_short,
  input  logic       inc_long,
  input  logic       mode_12h,
  input  logic [7:0] alarm_hr,
  input  logic [7:0] alarm_min,
  input  logic       alarm_arm,
  input  logic       alarm_ack,
  output logic [3:0] hr_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] cs_ones,
  output logic       pm,
  output logic       tick_1hz,
  output logic       alarm_hit
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RW  = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

  logic [PW-1:0] presc;
  logic          tick;
  tk_state_t     state;
  logic          inc_q;
  logic [RW-1:0] rep;
  logic          rep_step;
  logic          set_bump;
  logic          run;
  logic          cc_inc, ss_inc, mm_inc, hh_inc, mm_carry, hh_carry_unused;
  logic          ent_clr;
  logic          mode_q;
  bcd_t          hh_t, hh_o;

  assign tick = (presc == PW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) presc <= '0;
    else     presc <= tick ? '0 : presc + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= TK_RUN;
    else     state <= setting_enable ? TK_SET : TK_RUN;
  end

  // Repeat counter steps on the REPEAT_TICKS-th tick of a hold, then every REPEAT_TICKS
  assign rep_step = inc_long && tick && (rep == RW'(REPEAT_TICKS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      inc_q <= 1'b0;
      rep   <= '0;
    end else begin
      inc_q <= inc_short;
      if (!inc_long)  rep <= '0;
      else if (tick)  rep <= rep_step ? '0 : rep + RW'(1);
    end
  end

  // Edge and repeat step OR together, so a coincidence yields a single +1
  assign set_bump = setting_enable && ((inc_short && !inc_q) || rep_step);
  assign run      = !setting_enable;
  assign ent_clr  = setting_enable && (state == TK_RUN);
  assign cc_inc   = run && enable && tick;
  assign mm_inc   = run ? ss_inc_carry() : (set_bump && set_hr_or_min);
  assign hh_inc   = run ? mm_carry : (set_bump && !set_hr_or_min);

  logic ss_carry;
  function automatic logic ss_inc_carry();
    return ss_carry;
  endfunction

  bcd_pair_counter #(.MAX_TENS(CS_MAX[7:4]), .MAX_ONES(CS_MAX[3:0])) u_cc (
    .clk(clk), .rst(rst), .inc(cc_inc), .clr(ent_clr),
    .carry_out(ss_inc), .tens(cs_tens), .ones(cs_ones)
  );

  bcd_pair_counter #(.MAX_TENS(SEC_MAX[7:4]), .MAX_ONES(SEC_MAX[3:0])) u_ss (
    .clk(clk), .rst(rst), .inc(ss_inc), .clr(ent_clr),
    .carry_out(ss_carry), .tens(sec_tens), .ones(sec_ones)
  );

  bcd_pair_counter #(.MAX_TENS(MIN_MAX[7:4]), .MAX_ONES(MIN_MAX[3:0])) u_mm (
    .clk(clk), .rst(rst), .inc(mm_inc), .clr(1'b0),
    .carry_out(mm_carry), .tens(min_tens), .ones(min_ones)
  );

  bcd_pair_counter #(.MAX_TENS(HR_MAX[7:4]), .MAX_ONES(HR_MAX[3:0])) u_hh (
    .clk(clk), .rst(rst), .inc(hh_inc), .clr(1'b0),
    .carry_out(hh_carry_unused), .tens(hh_t), .ones(hh_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_1hz <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      tick_1hz <= ss_inc;
      mode_q   <= mode_12h;
    end
  end

  // Display mode is registered; internal hours stay 24h
  assign {hr_tens, hr_ones} = mode_q ? to_12h({hh_t, hh_o}) : {hh_t, hh_o};
  assign pm                 = ({hh_t, hh_o} >= 8'h12);

`ifdef BCD_TIMEKEEPER_ALARM_EN
  logic alarm_match;

  assign alarm_match = alarm_arm && run &&
                       ({hh_t, hh_o} == alarm_hr) &&
                       ({min_tens, min_ones} == alarm_min) &&
                       ({sec_tens, sec_ones, cs_tens, cs_ones} == 16'h0000);

  always_ff @(posedge clk) begin
    if (rst)                          alarm_hit <= 1'b0;
    else if (alarm_ack || !alarm_arm) alarm_hit <= 1'b0;
    else if (alarm_match)             alarm_hit <= 1'b1;
  end
`else
  logic alarm_unused;

  assign alarm_unused = ^{alarm_hr, alarm_min, alarm_arm, alarm_ack};
  assign alarm_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Scoreboard bench: a time-of-day model predicts every cycle's outputs; a monitor compares.
module tb_bcd_timekeeper;

  localparam int CLK_HZ  = 400;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int RT      = 5;
`ifdef BCD_TIMEKEEPER_ALARM_EN
  localparam bit ALARM = 1'b1;
`else
  localparam bit ALARM = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, enable, setting_enable, set_hr_or_min, inc_short, inc_long, mode_12h;
  logic [7:0] alarm_hr, alarm_min;
  logic       alarm_arm, alarm_ack;
  logic [3:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones;
  logic       pm, tick_1hz, alarm_hit;

  bcd_timekeeper #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .REPEAT_TICKS(RT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .setting_enable(setting_enable),
    .set_hr_or_min(set_hr_or_min), .inc_short(inc_short), .inc_long(inc_long),
    .mode_12h(mode_12h), .alarm_hr(alarm_hr), .alarm_min(alarm_min),
    .alarm_arm(alarm_arm), .alarm_ack(alarm_ack),
    .hr_tens(hr_tens), .hr_ones(hr_ones), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .cs_tens(cs_tens), .cs_ones(cs_ones),
    .pm(pm), .tick_1hz(tick_1hz), .alarm_hit(alarm_hit)
  );

  typedef struct packed {
    logic [31:0] dig;
    logic        pm;
    logic        t1;
    logic        hit;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e, mon_a;
  int   vectors = 0, miscompares = 0, t1_seen = 0, mon_cyc = 0;

  // Model: hours, minutes, centiseconds within the minute, plus prescaler/repeat counts
  int m_hh, m_mm, m_cs, m_presc, m_rep;
  bit m_incq, m_modeq, m_hit, m_t1;

  function automatic logic [7:0] bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int bin(logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic int disp_hr();
    if (!m_modeq)    return m_hh;
    if (m_hh == 0)   return 12;
    if (m_hh > 12)   return m_hh - 12;
    return m_hh;
  endfunction

  function automatic logic [31:0] dut_dig();
    return {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones};
  endfunction

  task automatic cycle();
    bit   tick, rise, step, match;
    exp_t e;
    if (rst) begin
      m_hh = 0; m_mm = 0; m_cs = 0; m_presc = 0; m_rep = 0;
      m_incq = 0; m_modeq = 0; m_hit = 0; m_t1 = 0;
    end else begin
      tick    = (m_presc == DIV - 1);
      m_presc = tick ? 0 : m_presc + 1;
      rise    = inc_short && !m_incq;
      step    = 0;
      if (!inc_long) m_rep = 0;
      else if (tick) begin
        if (m_rep == RT - 1) begin m_rep = 0; step = 1; end
        else m_rep++;
      end
      match = ALARM && alarm_arm && !setting_enable && m_hh == bin(alarm_hr) &&
              m_mm == bin(alarm_min) && m_cs == 0;
      m_hit = (alarm_ack || !alarm_arm) ? 1'b0 : (m_hit || match);
      m_t1  = 0;
      if (setting_enable) begin
        m_cs = 0;
        if (rise || step) begin
          if (set_hr_or_min) m_mm = (m_mm + 1) % 60;
          else               m_hh = (m_hh + 1) % 24;
        end
      end else if (tick && enable) begin
        m_cs++;
        if (m_cs % 100 == 0) m_t1 = 1;
        if (m_cs == 6000) begin
          m_cs = 0;
          m_mm++;
          if (m_mm == 60) begin m_mm = 0; m_hh = (m_hh + 1) % 24; end
        end
      end
      m_incq  = inc_short;
      m_modeq = mode_12h;
    end
    e.dig = {bcd(disp_hr()), bcd(m_mm), bcd(m_cs / 100), bcd(m_cs % 100)};
    e.pm  = (m_hh >= 12);
    e.t1  = m_t1;
    e.hit = m_hit;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_short();
    inc_short = 1'b1; cycle();
    inc_short = 1'b0; cycle();
  endtask

  task automatic set_hours(int h);
    set_hr_or_min = 1'b0;
    while (m_hh != h) pulse_short();
  endtask

  task automatic set_mins(int m);
    set_hr_or_min = 1'b1;
    while (m_mm != m) pulse_short();
  endtask

  // Monitor: one compare per clock edge that has a prediction queued
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_a = {dut_dig(), pm, tick_1hz, alarm_hit};
        vectors++;
        if (tick_1hz === 1'b1) t1_seen++;
        if (mon_a !== mon_e) begin
          miscompares++;
          $display("FAIL cycle %0d: dut dig=%h pm=%b t1=%b hit=%b, model dig=%h pm=%b t1=%b hit=%b",
                   mon_cyc, mon_a.dig, mon_a.pm, mon_a.t1, mon_a.hit,
                   mon_e.dig, mon_e.pm, mon_e.t1, mon_e.hit);
        end
        mon_cyc++;
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b1; setting_enable = 1'b0; set_hr_or_min = 1'b0;
    inc_short = 1'b0; inc_long = 1'b0; mode_12h = 1'b0;
    alarm_hr = 8'h00; alarm_min = 8'h01; alarm_arm = 1'b1; alarm_ack = 1'b0;
    @(negedge clk);
    repeat (3) cycle();
    check("reset_state", {dut_dig(), 5'b0, pm, tick_1hz, alarm_hit}, 32'h0);
    rst = 1'b0;

    // One minute of free running
    t1_seen = 0;
    repeat (60 * 100 * DIV) cycle();
    check("one_minute", dut_dig(), 32'h0001_0000);
    check("tick_1hz_count", t1_seen, 60);
    cycle();
    check("alarm_at_match", {31'b0, alarm_hit}, {31'b0, ALARM});
    alarm_ack = 1'b1; cycle(); alarm_ack = 1'b0;
    check("alarm_ack", {31'b0, alarm_hit}, 32'h0);
    alarm_arm = 1'b0;

    // Preload 23:59, run to 59.99, then one tick to midnight
    setting_enable = 1'b1; cycle();
    check("set_entry_clear", dut_dig() & 32'h0000_ffff, 32'h0);
    set_hours(23);
    set_mins(59);
    setting_enable = 1'b0;
    while (m_cs != 5999) cycle();
    check("pre_midnight", dut_dig(), 32'h2359_5999);
    check("pm_before", {31'b0, pm}, 32'h1);
    for (int i = 0; i < DIV && m_cs != 0; i++) cycle();
    check("midnight", dut_dig(), 32'h0);
    check("pm_after", {31'b0, pm}, 32'h0);

    // Minute wrap in SET does not touch hours; a held inc_short only counts once
    setting_enable = 1'b1; cycle();
    set_mins(59);
    inc_short = 1'b1; cycle();
    check("min_wrap", {hr_tens, hr_ones, min_tens, min_ones}, 16'h0000);
    repeat (10) cycle();
    check("short_held", {min_tens, min_ones}, 8'h00);
    inc_short = 1'b0; cycle();

    // Hold-to-repeat, then an edge landing on a repeat step
    set_hr_or_min = 1'b0;
    inc_long = 1'b1;
    repeat (3 * RT * DIV) cycle();
    check("repeat_3", {hr_tens, hr_ones}, 8'h03);
    while (!(m_rep == RT - 1 && m_presc == DIV - 1)) cycle();
    inc_short = 1'b1; cycle();
    check("coincident_step", {hr_tens, hr_ones}, 8'h04);
    inc_short = 1'b0; inc_long = 1'b0; cycle();

    // 12h display
    set_hours(0);
    mode_12h = 1'b1; cycle();
    check("disp_00", {hr_tens, hr_ones, 7'b0, pm}, 16'h1200);
    set_hours(12);
    check("disp_12", {hr_tens, hr_ones, 7'b0, pm}, 16'h1201);
    set_hours(13);
    check("disp_13", {hr_tens, hr_ones, 7'b0, pm}, 16'h0101);
    mode_12h = 1'b0; cycle();
    check("disp_24h", {hr_tens, hr_ones}, 8'h13);

    // Reset mid-count
    setting_enable = 1'b0;
    repeat (500) cycle();
    rst = 1'b1; cycle();
    check("mid_reset", {dut_dig(), 5'b0, pm, tick_1hz, alarm_hit}, 32'h0);
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 5000; i++) begin
      rst            = ($urandom_range(0, 499) == 0);
      enable         = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) == 0) setting_enable = ~setting_enable;
      if ($urandom_range(0, 19) == 0) set_hr_or_min  = ~set_hr_or_min;
      if ($urandom_range(0, 2) == 0)  inc_short      = ~inc_short;
      if ($urandom_range(0, 29) == 0) inc_long       = ~inc_long;
      if ($urandom_range(0, 49) == 0) mode_12h       = ~mode_12h;
      if ($urandom_range(0, 199) == 0) begin
        alarm_hr  = bcd(m_hh);
        alarm_min = bcd(m_mm);
      end
      if ($urandom_range(0, 99) == 0) alarm_arm = ~alarm_arm;
      alarm_ack = ($urandom_range(0, 49) == 0);
      cycle();
    end

    @(posedge clk); #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
